// File: rtl/gate_alarm_ctrl.sv
// Front-gate alarm controller: entry delay, alarm and gate-open hold phases.
// The remaining phase length is exposed on fm.
// Optional macro ALARM_COUNT_EN adds a saturating alarm_cnt output that counts alarm entries.
module gate_alarm_ctrl #(
  parameter int ENTRY_DLY = 16,
  parameter int ALARM_LEN = 64,
  parameter int HOLD      = 8,
  parameter int CW        = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          arm,
  input  logic          frontgate_t,
  input  logic          request_t,
  output logic [CW-1:0] fm,
  output logic          gate_open,
  output logic          siren,
  output logic [2:0]    state_o,
  output logic          busy
`ifdef ALARM_COUNT_EN
  ,
  output logic [7:0]    alarm_cnt
`endif
);

  localparam longint FM_MAX = (64'd1 << CW) - 64'd1;

  if (CW < 1 || CW > 32 ||
      ENTRY_DLY < 0 || longint'(ENTRY_DLY) > FM_MAX ||
      ALARM_LEN < 0 || longint'(ALARM_LEN) > FM_MAX ||
      HOLD < 0      || longint'(HOLD) > FM_MAX) begin : g_bad_param
    $error("gate_alarm_ctrl: a phase length does not fit in CW bits");
  end

  typedef enum logic [2:0] {
    S_DISARMED = 3'd0,
    S_ARMED    = 3'd1,
    S_ENTRY    = 3'd2,
    S_ALARM    = 3'd3,
    S_OPEN     = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] fm_q, fm_d;
  logic          gate_open_q, gate_open_d;
  logic          siren_q, siren_d;
  logic          busy_q, busy_d;
  logic [CW-1:0] fm_dec;

  assign fm_dec = fm_q - CW'(1);

  always_comb begin
    state_d = state_q;
    fm_d    = '0;
    case (state_q)
      S_DISARMED: begin
        if (request_t) begin
          state_d = S_OPEN;
          fm_d    = CW'(HOLD);
        end else if (arm) begin
          state_d = S_ARMED;
        end
      end
      S_ARMED: begin
        // A valid request outranks a simultaneous gate trigger.
        if (request_t) begin
          state_d = S_DISARMED;
        end else if (frontgate_t) begin
          state_d = S_ENTRY;
          fm_d    = CW'(ENTRY_DLY);
        end
      end
      S_ENTRY: begin
        if (request_t) begin
          state_d = S_DISARMED;
        end else if (fm_q != '0) begin
          fm_d = fm_dec;
        end else begin
          state_d = S_ALARM;
          fm_d    = CW'(ALARM_LEN);
        end
      end
      S_ALARM: begin
        if (request_t) begin
          state_d = S_DISARMED;
        end else if (fm_q != '0) begin
          fm_d = fm_dec;
        end else begin
          state_d = S_ARMED;
        end
      end
      S_OPEN: begin
        // Each passage through the gate restarts the hold.
        if (frontgate_t) begin
          fm_d = CW'(HOLD);
        end else if (fm_q != '0) begin
          fm_d = fm_dec;
        end else begin
          state_d = S_DISARMED;
        end
      end
      default: begin
        state_d = S_DISARMED;
      end
    endcase
    gate_open_d = (state_d == S_OPEN);
    siren_d     = (state_d == S_ALARM);
    busy_d      = (state_d == S_ENTRY) || (state_d == S_ALARM) || (state_d == S_OPEN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_DISARMED;
      fm_q        <= '0;
      gate_open_q <= 1'b0;
      siren_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      fm_q        <= fm_d;
      gate_open_q <= gate_open_d;
      siren_q     <= siren_d;
      busy_q      <= busy_d;
    end
  end

  assign fm        = fm_q;
  assign gate_open = gate_open_q;
  assign siren     = siren_q;
  assign busy      = busy_q;
  assign state_o   = state_q;

`ifdef ALARM_COUNT_EN
  logic [7:0] alarm_cnt_q, alarm_cnt_d;

  always_comb begin
    alarm_cnt_d = alarm_cnt_q;
    if (state_q == S_ENTRY && state_d == S_ALARM && alarm_cnt_q != 8'hFF)
      alarm_cnt_d = alarm_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) alarm_cnt_q <= 8'd0;
    else        alarm_cnt_q <= alarm_cnt_d;
  end

  assign alarm_cnt = alarm_cnt_q;
`endif

endmodule

// File: tb/tb_gate_alarm_ctrl.sv
// Directed self-checking bench for gate_alarm_ctrl with default parameters.
// Inputs change 1 time unit after each rising edge, and outputs are sampled at that same point.
module tb_gate_alarm_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       arm, frontgate_t, request_t;
  logic [7:0] fm;
  logic       gate_open, siren, busy;
  logic [2:0] state_o;
`ifdef ALARM_COUNT_EN
  logic [7:0] alarm_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  gate_alarm_ctrl dut (
    .clk(clk), .reset(reset), .arm(arm), .frontgate_t(frontgate_t),
    .request_t(request_t), .fm(fm), .gate_open(gate_open), .siren(siren),
    .state_o(state_o), .busy(busy)
`ifdef ALARM_COUNT_EN
    , .alarm_cnt(alarm_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input int st, input int f, input int g, input int s, input int b);
    chk({tag, ".state"}, state_o, st);
    chk({tag, ".fm"}, fm, f);
    chk({tag, ".gate"}, gate_open, g);
    chk({tag, ".siren"}, siren, s);
    chk({tag, ".busy"}, busy, b);
  endtask

  initial begin
    reset = 1'b0; arm = 1'b0; frontgate_t = 1'b0; request_t = 1'b0;
    #1;
    chk_all("rst_async", 0, 0, 0, 0, 0);
    tick(3);
    chk_all("rst_hold", 0, 0, 0, 0, 0);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chk_all("idle", 0, 0, 0, 0, 0);
    end

    // Full entry-delay timeout into alarm, then automatic re-arm.
    arm = 1'b1; tick(1); arm = 1'b0;
    chk_all("armed", 1, 0, 0, 0, 0);
    frontgate_t = 1'b1; tick(1); frontgate_t = 1'b0;
    chk_all("entry_k", 2, 16, 0, 0, 1);
    tick(15);
    chk_all("entry_k15", 2, 1, 0, 0, 1);
    tick(1);
    chk_all("entry_k16", 2, 0, 0, 0, 1);
    tick(1);
    chk_all("alarm_k17", 3, 64, 0, 1, 1);
    tick(64);
    chk_all("alarm_k81", 3, 0, 0, 1, 1);
    tick(1);
    chk_all("rearm_k82", 1, 0, 0, 0, 0);

    // Disarm during the entry delay; siren must never sound.
    frontgate_t = 1'b1; tick(1); frontgate_t = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick(1);
      chk("abort.siren", siren, 0);
      chk("abort.fm", fm, 16 - i);
    end
    request_t = 1'b1; tick(1); request_t = 1'b0;
    chk_all("abort_k5", 0, 0, 0, 0, 0);

    // Granted request opens the gate; a passage reloads the hold.
    request_t = 1'b1; tick(1); request_t = 1'b0;
    chk_all("open_k", 4, 8, 1, 0, 1);
    tick(3);
    chk("open_k3.fm", fm, 5);
    frontgate_t = 1'b1; request_t = 1'b1; tick(1); frontgate_t = 1'b0; request_t = 1'b0;
    chk_all("open_reload", 4, 8, 1, 0, 1);
    tick(8);
    chk_all("open_k12", 4, 0, 1, 0, 1);
    tick(1);
    chk_all("open_done", 0, 0, 0, 0, 0);

    // The frontgate_t input is ignored while DISARMED.
    frontgate_t = 1'b1; tick(1); frontgate_t = 1'b0;
    chk_all("disarm_fg", 0, 0, 0, 0, 0);

    // In ARMED, a request_t on the same edge as frontgate_t takes priority.
    arm = 1'b1; tick(1); arm = 1'b0;
    frontgate_t = 1'b1; request_t = 1'b1; tick(1); frontgate_t = 1'b0; request_t = 1'b0;
    chk_all("prio_same_edge", 0, 0, 0, 0, 0);

    // A request on the edge where fm==0 beats the timeout.
    arm = 1'b1; tick(1); arm = 1'b0;
    frontgate_t = 1'b1; tick(1); frontgate_t = 1'b0;
    frontgate_t = 1'b1; tick(1); frontgate_t = 1'b0;
    chk("entry_no_restart.fm", fm, 15);
    tick(15);
    chk_all("entry_fm0", 2, 0, 0, 0, 1);
    request_t = 1'b1; tick(1); request_t = 1'b0;
    chk_all("prio_timeout", 0, 0, 0, 0, 0);

    // Reset asserted mid-alarm acts asynchronously.
    arm = 1'b1; tick(1); arm = 1'b0;
    frontgate_t = 1'b1; tick(1); frontgate_t = 1'b0;
    tick(17);
    chk_all("alarm2", 3, 64, 0, 1, 1);
    tick(34);
    chk_all("alarm2_fm30", 3, 30, 0, 1, 1);
`ifdef ALARM_COUNT_EN
    chk("cnt_two", alarm_cnt, 2);
`endif
    #2 reset = 1'b0;
    #1;
    chk_all("rst_mid_alarm", 0, 0, 0, 0, 0);
`ifdef ALARM_COUNT_EN
    chk("cnt_rst", alarm_cnt, 0);
`endif
    tick(1);
    reset = 1'b1;

    // Three alarms, each cancelled by a request.
    for (int a = 0; a < 3; a++) begin
      arm = 1'b1; tick(1); arm = 1'b0;
      frontgate_t = 1'b1; tick(1); frontgate_t = 1'b0;
      tick(17);
      chk("loop.siren", siren, 1);
      request_t = 1'b1; tick(1); request_t = 1'b0;
      chk_all("loop.cancel", 0, 0, 0, 0, 0);
    end
`ifdef ALARM_COUNT_EN
    chk("cnt_three", alarm_cnt, 3);
    #2 reset = 1'b0;
    #1;
    chk("cnt_clear", alarm_cnt, 0);
    reset = 1'b1;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gate_alarm_ctrl.md
Name: gate_alarm_ctrl

Overview:
- Front-gate alarm controller; the responder on the alarm interface.
- Accepts arm, gate-trigger (frontgate_t) and access-request (request_t) pulses from the stimulus side.
- Sequences entry delay, alarm, and gate-open hold phases.
- Exposes the remaining phase cycle count on fm, so the driving side can wait exactly fm cycles before the next stimulus.

Parameters:
ENTRY_DLY, 16, cycles allowed between gate trigger and alarm while armed
ALARM_LEN, 64, cycles the siren sounds before automatic re-arm
HOLD, 8, cycles the gate stays open after a granted request
CW, 8, width of fm/phase counter; ENTRY_DLY, ALARM_LEN and HOLD must each be <= 2^CW-1 (elaboration error otherwise)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
arm  input  1  arm request, level sampled each edge
frontgate_t  input  1  gate trigger, sampled each edge
request_t  input  1  valid access request (disarm/open), sampled each edge
fm  output  CW  remaining cycles of current timed phase; 0 when untimed
gate_open  output  1  gate actuator enable
siren  output  1  alarm siren
state_o  output  3  encoded state: 0 DISARMED, 1 ARMED, 2 ENTRY, 3 ALARM, 4 OPEN
busy  output  1  high in ENTRY, ALARM, OPEN (fm counting)

Behaviour:
- All outputs registered, decoded from state/counter registers.
- Inputs sampled at rising edge k; the resulting state/fm is visible after edge k.
- Reset low, at any time including mid-phase: immediately state=DISARMED, fm=0, gate_open=0, siren=0, busy=0. Leaves reset on the first edge with reset high.
- DISARMED:
  - request_t -> OPEN, fm=HOLD.
  - else arm -> ARMED.
  - frontgate_t ignored.
- ARMED:
  - request_t -> DISARMED (has priority over a simultaneous frontgate_t).
  - else frontgate_t -> ENTRY, fm=ENTRY_DLY.
  - arm ignored.
- ENTRY:
  - request_t -> DISARMED, fm=0 (priority over timeout, including the edge where fm==0).
  - else fm>0: fm decrements by 1.
  - else fm==0: -> ALARM, fm=ALARM_LEN.
  - ENTRY therefore lasts ENTRY_DLY+1 cycles.
  - frontgate_t ignored; does not restart the delay.
- ALARM:
  - siren=1.
  - request_t -> DISARMED, fm=0.
  - else fm>0: decrements.
  - else fm==0: -> ARMED, fm=0.
- OPEN:
  - gate_open=1.
  - frontgate_t reloads fm=HOLD (passage extends hold).
  - else fm>0: decrements.
  - fm==0 -> DISARMED.
  - request_t ignored.
- A phase length parameter of 0 gives a one-cycle phase.
- Counter never wraps; decrement only when fm>0.
- fm=0 in DISARMED and ARMED.
- Unused state encodings (5-7) recover to DISARMED on the next edge.

Optional Feature:
- Macro ALARM_COUNT_EN.
- Defined:
  - Adds output alarm_cnt [7:0], counting entries into ALARM (ENTRY->ALARM transitions).
  - Saturates at 255; cleared only by reset.
  - Reset value 0.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset low 3 cycles, release, idle 5 cycles -> state_o=0, fm=0, gate_open=0, siren=0 throughout.
- arm pulse, then frontgate_t at edge k, no request -> state_o=2, fm=16 after k; fm=0 after k+16; state_o=3, siren=1, fm=64 after k+17; state_o=1, siren=0 after k+82.
- ARMED, frontgate_t, then request_t 5 cycles later -> state_o=0, fm=0, siren never asserted.
- DISARMED request_t at edge k -> gate_open=1, fm=8; frontgate_t at k+4 reloads fm=8; gate_open drops after k+13 (state_o=0).
- ARMED with frontgate_t and request_t on the same edge -> state_o=0, fm=0. ENTRY with request_t on the edge where fm==0 -> DISARMED, no alarm.
- Reset asserted mid-ALARM (fm=30) -> siren=0, state_o=0, fm=0 asynchronously, before the next edge. With ALARM_COUNT_EN: 3 alarms -> alarm_cnt=3; reset -> 0.
